// File: rtl/croc_xilinx_pad_ctrl_if.sv
// Pad/core signal bundle between the FPGA pad ring and croc_soc.
// slave = pad controller, master = the side that owns pads and core peripheral.
interface croc_xilinx_pad_ctrl_if #(
   parameter int unsigned NumCh = 1
);
   logic [NumCh-1:0] pad_i;
   logic [NumCh-1:0] pad_o;
   logic [NumCh-1:0] pad_oe_o;
   logic [NumCh-1:0] core_o_i;
   logic [NumCh-1:0] core_oe_i;
   logic [NumCh-1:0] core_i_o;
   logic [NumCh-1:0] edge_o;

   modport slave (
      input  pad_i, core_o_i, core_oe_i,
      output pad_o, pad_oe_o, core_i_o, edge_o
   );

   modport master (
      output pad_i, core_o_i, core_oe_i,
      input  pad_o, pad_oe_o, core_i_o, edge_o
   );
endinterface

// File: rtl/croc_xilinx_pad_ctrl.sv
// Pad-side controller: ref-clock divider, 2-flop sync + glitch filter per input,
// guarded output enable per channel. Input latency 2+FilterLen, oe latency GuardCycles+1; no backpressure.
module croc_xilinx_pad_ctrl #(
   parameter int unsigned NumCh       = 1,
   parameter int unsigned DivWidth    = 16,
   parameter int unsigned FilterLen   = 4,
   parameter int unsigned GuardCycles = 2,
   parameter bit          InitVal     = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [DivWidth-1:0] div_half_i,
   output logic                ref_clk_o,
   croc_xilinx_pad_ctrl_if.slave io
);

   localparam int unsigned FW = $clog2(FilterLen) + 1;
   localparam int unsigned GW = $clog2(GuardCycles) + 1;
   localparam logic [FW-1:0] FLast = FW'(FilterLen - 1);
   localparam logic [GW-1:0] GLast = GW'((GuardCycles == 0) ? 0 : GuardCycles - 1);
   localparam logic [DivWidth-1:0] DivOne = DivWidth'(1);

   typedef enum logic [1:0] {IDLE, GUARD, DRIVE} guard_state_e;

   // ---------------- reference clock divider ----------------
   logic [DivWidth-1:0] div_cnt;
   logic [DivWidth-1:0] div_eff;

   assign div_eff = (div_half_i == '0) ? DivOne : div_half_i;

   // ">=" lets a shrinking divisor wrap immediately instead of running to overflow
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_cnt   <= '0;
         ref_clk_o <= 1'b0;
      end else if (div_cnt >= div_eff - DivOne) begin
         div_cnt   <= '0;
         ref_clk_o <= ~ref_clk_o;
      end else begin
         div_cnt   <= div_cnt + DivOne;
      end
   end

   // ---------------- input synchroniser ----------------
   logic [NumCh-1:0] sync_q1;
   logic [NumCh-1:0] sync_q2;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q1 <= {NumCh{InitVal}};
         sync_q2 <= {NumCh{InitVal}};
      end else begin
         sync_q1 <= io.pad_i;
         sync_q2 <= sync_q1;
      end
   end

   // ---------------- per-channel filter and guard ----------------
   for (genvar g = 0; g < NumCh; g++) begin : g_ch
      logic          core_i_q;
      logic          edge_q;
      logic [FW-1:0] fcnt;
      guard_state_e  state;
      logic [GW-1:0] gcnt;
      logic          oe_q;
      logic          pad_q;

      // input path keeps running while driving, so the SoC can read back for collisions
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            core_i_q <= InitVal;
            edge_q   <= 1'b0;
            fcnt     <= '0;
         end else if (sync_q2[g] == core_i_q) begin
            fcnt     <= '0;
            edge_q   <= 1'b0;
         end else if (fcnt == FLast) begin
            core_i_q <= sync_q2[g];
            fcnt     <= '0;
            edge_q   <= 1'b1;
         end else begin
            fcnt     <= fcnt + FW'(1);
            edge_q   <= 1'b0;
         end
      end

      // oe is registered from the next state so release is never delayed by the guard
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state <= IDLE;
            gcnt  <= '0;
            oe_q  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (io.core_oe_i[g]) begin
                     if (GuardCycles == 0) begin
                        state <= DRIVE;
                        oe_q  <= 1'b1;
                     end else begin
                        state <= GUARD;
                        gcnt  <= '0;
                        oe_q  <= 1'b0;
                     end
                  end else begin
                     oe_q <= 1'b0;
                  end
               end
               GUARD: begin
                  if (!io.core_oe_i[g]) begin
                     state <= IDLE;
                     oe_q  <= 1'b0;
                  end else if (gcnt == GLast) begin
                     state <= DRIVE;
                     oe_q  <= 1'b1;
                  end else begin
                     gcnt  <= gcnt + GW'(1);
                     oe_q  <= 1'b0;
                  end
               end
               DRIVE: begin
                  if (!io.core_oe_i[g]) begin
                     state <= IDLE;
                     oe_q  <= 1'b0;
                  end else begin
                     oe_q  <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  oe_q  <= 1'b0;
               end
            endcase
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) pad_q <= 1'b0;
         else         pad_q <= io.core_o_i[g];
      end

      assign io.core_i_o[g] = core_i_q;
      assign io.edge_o[g]   = edge_q;
      assign io.pad_oe_o[g] = oe_q;
      assign io.pad_o[g]    = pad_q;
   end

endmodule

// File: tb/tb_croc_xilinx_pad_ctrl.sv
// Directed bench for croc_xilinx_pad_ctrl with NumCh=3, FilterLen=4, GuardCycles=2.
module tb_croc_xilinx_pad_ctrl;

   logic        clk;
   logic        rst_n;
   logic [15:0] div_half;
   logic        ref_clk;
   int          checks;
   int          errors;
   int          cyc;
   logic [2:0]  acc;

   croc_xilinx_pad_ctrl_if #(.NumCh(3)) bus ();

   croc_xilinx_pad_ctrl #(
      .NumCh(3), .DivWidth(16), .FilterLen(4), .GuardCycles(2), .InitVal(1'b0)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .div_half_i (div_half),
      .ref_clk_o  (ref_clk),
      .io         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // cycles until ref_clk changes, bounded
   task automatic wait_toggle(input int limit, output int cycles);
      logic r0;
      r0 = ref_clk;
      cycles = 0;
      do begin
         tick(1);
         cycles++;
      end while (ref_clk == r0 && cycles <= limit);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      div_half = 16'd3;
      bus.pad_i = 3'b000;
      bus.core_o_i = 3'b000;
      bus.core_oe_i = 3'b000;
      #1;
      check("rst_ref", {31'd0, ref_clk}, 32'd0);
      check("rst_oe", {29'd0, bus.pad_oe_o}, 32'd0);
      check("rst_pad_o", {29'd0, bus.pad_o}, 32'd0);
      check("rst_core_i", {29'd0, bus.core_i_o}, 32'd0);
      check("rst_edge", {29'd0, bus.edge_o}, 32'd0);
      tick(2);
      @(negedge clk) rst_n = 1'b1;

      // divider
      wait_toggle(20, cyc); check("div3_first", cyc, 3);
      wait_toggle(20, cyc); check("div3_second", cyc, 3);
      div_half = 16'd0;
      wait_toggle(20, cyc); check("div0_a", cyc, 1);
      wait_toggle(20, cyc); check("div0_b", cyc, 1);
      div_half = 16'd100;
      wait_toggle(300, cyc); check("div100", cyc, 100);
      tick(50);
      div_half = 16'd5;
      wait_toggle(20, cyc); check("div_shrink_wrap", cyc, 1);
      wait_toggle(20, cyc); check("div5", cyc, 5);

      // ch1 input rise alongside ch2 drive request
      bus.pad_i[1] = 1'b1;
      bus.core_oe_i[2] = 1'b1;
      bus.core_o_i[2] = 1'b1;
      tick(1);
      check("pad_o_lat", {29'd0, bus.pad_o}, 32'h4);
      check("oe_e1", {29'd0, bus.pad_oe_o}, 32'h0);
      tick(1);
      check("oe_e2", {29'd0, bus.pad_oe_o}, 32'h0);
      tick(1);
      check("oe_e3", {29'd0, bus.pad_oe_o}, 32'h4);
      check("core_i_e3", {29'd0, bus.core_i_o}, 32'h0);
      tick(2);
      check("core_i_e5", {29'd0, bus.core_i_o}, 32'h0);
      check("edge_e5", {29'd0, bus.edge_o}, 32'h0);
      tick(1);
      check("core_i_e6", {29'd0, bus.core_i_o}, 32'h2);
      check("edge_e6", {29'd0, bus.edge_o}, 32'h2);
      tick(1);
      check("edge_e7", {29'd0, bus.edge_o}, 32'h0);
      bus.core_oe_i[2] = 1'b0;
      tick(1);
      check("oe_release", {29'd0, bus.pad_oe_o}, 32'h0);

      // 3-cycle glitch on ch0
      bus.pad_i[0] = 1'b1;
      tick(3);
      bus.pad_i[0] = 1'b0;
      acc = 3'b000;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         acc = acc | bus.edge_o;
      end
      check("glitch_edge", {29'd0, acc}, 32'h0);
      check("glitch_core_i", {29'd0, bus.core_i_o}, 32'h2);

      // ch0 request dropped inside the guard window
      bus.core_oe_i[0] = 1'b1;
      tick(2);
      bus.core_oe_i[0] = 1'b0;
      acc = 3'b000;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         acc = acc | bus.pad_oe_o;
      end
      check("short_req_oe", {29'd0, acc}, 32'h0);
      bus.core_oe_i[0] = 1'b1;
      tick(2);
      check("guard_restart_e2", {29'd0, bus.pad_oe_o}, 32'h0);
      tick(1);
      check("guard_restart_e3", {29'd0, bus.pad_oe_o}, 32'h1);

      // ch1 falling edge
      bus.pad_i[1] = 1'b0;
      tick(5);
      check("fall_e5", {29'd0, bus.core_i_o}, 32'h2);
      tick(1);
      check("fall_e6", {29'd0, bus.core_i_o}, 32'h0);
      check("fall_edge", {29'd0, bus.edge_o}, 32'h2);

      // reset while ch0 drives and ch2 is mid-filter
      bus.pad_i[1] = 1'b1;
      tick(6);
      check("pre_rst_core_i", {29'd0, bus.core_i_o}, 32'h2);
      bus.core_o_i[0] = 1'b1;
      bus.pad_i[2] = 1'b1;
      tick(2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_oe", {29'd0, bus.pad_oe_o}, 32'h0);
      check("mid_rst_core_i", {29'd0, bus.core_i_o}, 32'h0);
      check("mid_rst_pad_o", {29'd0, bus.pad_o}, 32'h0);
      check("mid_rst_ref", {31'd0, ref_clk}, 32'd0);
      tick(2);
      @(negedge clk) rst_n = 1'b1;
      tick(1);
      check("post_rst_pad_o", {29'd0, bus.pad_o}, 32'h5);
      tick(1);
      check("post_rst_oe_r2", {29'd0, bus.pad_oe_o}, 32'h0);
      tick(1);
      check("post_rst_oe_r3", {29'd0, bus.pad_oe_o}, 32'h1);
      tick(2);
      check("post_rst_core_i_r5", {29'd0, bus.core_i_o}, 32'h0);
      tick(1);
      check("post_rst_core_i_r6", {29'd0, bus.core_i_o}, 32'h6);
      check("post_rst_edge_r6", {29'd0, bus.edge_o}, 32'h6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
